phase_bus_board_responder: RTL and testbench
============================================

Name: phase_bus_board_responder

Overview:
Emulates one I/O card on the Phase Bus, the responder end of the card-side bus driven by the Phase Bus command state machines. It decodes BOARD_X/AddessPortPin and the active-low RdP/WrP strobes, latches write data into card registers, drives read data back onto the bus, and runs the mux-latch / ADC-start sequence used by pb_adc4. It sits on the bench/emulation side of the bus and also serves as a loopback target on the board.

Parameters:
- BOARD_ID, 4'd1, card address this instance answers to.
- BOARD_ALL_CODE, 4'd5, broadcast board code; accepted for writes only.
- CLOCK_FREQUENCY, 27000000, system clock in Hz; informational only.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- BOARD_X  in  4  board select from the master
- AddessPortPin  in  3  port address: 0 OUT_LATCH, 1 IN_PORT, 3 PORT_MUX, 4 ADC_HIGH, 5 ADC_LOW
- RdP  in  1  read strobe, active-low
- WrP  in  1  write strobe, active-low
- bus_data_in  in  8  master-driven data (master Data_Out_Port)
- master_data_dir  in  1  master direction; 1 = master driving
- bus_data_out  out  8  responder read data
- bus_drive_en  out  1  responder drives the bus
- out_latch  out  8  card output register
- in_pins  in  8  card input pins, returned on an IN_PORT read
- adc_channel  out  3  latched mux channel
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  one-cycle conversion complete pulse
- adc_result  in  16  conversion result, valid with adc_done
- adc_busy  out  1  conversion in progress
- proto_error  out  1  sticky; set on RdP and WrP both low after synchronisation

Behaviour:
- Reset values: every output 0; internal MUX state IDLE; result register 0.
- Synchronisation:
  - RdP, WrP, BOARD_X, AddessPortPin and bus_data_in pass through 2-FF synchronisers.
  - Edges are detected on the synchronised strobes.
- Select:
  - sel_wr = (BOARD_X == BOARD_ID) || (BOARD_X == BOARD_ALL_CODE).
  - sel_rd = (BOARD_X == BOARD_ID).
  - Broadcast reads are never driven.
- Write:
  - Data, port and board are captured on the synchronised WrP rising edge (deassert), using the synchronised values from that cycle.
  - OUT_LATCH: out_latch updates on the cycle after the edge.
  - Writes to other ports are ignored, except PORT_MUX.
- PORT_MUX FSM: IDLE -> ARMED -> CONVERTING -> IDLE.
  - IDLE + mux write: adc_channel <= data[2:0]; go to ARMED.
  - ARMED + mux write: data is ignored; adc_start pulses for 1 cycle; adc_busy = 1; go to CONVERTING.
  - CONVERTING + adc_done: result register <= adc_result; adc_busy = 0; go to IDLE.
  - CONVERTING + mux write: ignored.
  - adc_done in any other state: ignored.
- Read:
  - Drive condition: synchronised RdP low, sel_rd, and synchronised master_data_dir == 0.
  - bus_drive_en asserts within 3 clocks of RdP falling (worst case: 2 sync stages plus 1 register).
  - bus_drive_en deasserts within 3 clocks of RdP rising or master_data_dir rising.
  - bus_data_out is held stable for the whole assertion.
  - Data by port: IN_PORT = synchronised in_pins sampled at assertion; ADC_HIGH = result[15:8]; ADC_LOW = result[7:0]; OUT_LATCH = out_latch readback; any other port = 8'hFF.
  - A read during CONVERTING returns the previous result.
- Contention: if master_data_dir rises while driving, bus_drive_en drops on the next synchronised cycle.
- Protocol error: RdP and WrP both low for 2 consecutive synchronised cycles sets proto_error.
  - That cycle drives nothing and captures nothing.
  - proto_error clears only on reset.
- Reset mid-operation:
  - Asynchronous reset clears all registers immediately and drops bus_drive_en.
  - An in-flight adc_done that arrives after reset is ignored (FSM is in IDLE).
- Back-to-back strobes: consecutive WrP pulses at least 2 clocks high/low are each captured. Shorter pulses are not guaranteed and must not corrupt state.

Decomposition:
- Shared package `phase_bus_pkg`:
  - port-address constants: OUT_LATCH, IN_PORT, PORT_MUX = 3, ADC_HIGH, ADC_LOW;
  - BOARD_ALL;
  - the mux FSM state typedef;
  - the strobe enable enum (ENABLE = 0, DISABLE = 1).
  
  The command state machines also use this package.
- One sub-module, `pb_strobe_sync`: a 2-FF synchroniser with rise/fall edge outputs, instantiated for RdP and WrP.

Test Plan:
1. Write, own board: BOARD_X=1, port 0, data 8'hA5, WrP low for 20 clocks -> out_latch = 8'hA5 within 4 clocks of WrP rising.
2. Broadcast write/read:
   - BOARD_X=5, port 0, data 8'h3C written -> out_latch = 8'h3C.
   - Then a read with BOARD_X=5 -> bus_drive_en stays 0.
3. ADC sequence:
   - Mux write 8'h06 -> adc_channel = 6.
   - Second mux write -> single adc_start pulse, adc_busy = 1.
   - adc_done with result 16'h1234 -> adc_busy = 0.
   - Reads of port 4/5 return 8'h12 / 8'h34.
4. Input read: in_pins = 8'h81, RdP low 20 clocks, master_data_dir = 0 -> bus_drive_en within 3 clocks, bus_data_out = 8'h81; drive released within 3 clocks of RdP rising.
5. Wrong board / contention:
   - BOARD_X=2 read -> no drive.
   - Read with master_data_dir = 1 -> no drive.
   - RdP and WrP both low 3 clocks -> proto_error = 1, out_latch unchanged.
6. Reset mid-conversion: reset asserted in CONVERTING, then adc_done after release -> adc_busy = 0, result still 0, all outputs at reset values.

Source files
------------

// File: rtl/phase_bus_board_responder_pkg.sv
// Phase Bus shared definitions: port map, board codes, mux FSM states.
// Also imported by the command state machines on the master side.
package phase_bus_pkg;

  localparam logic [2:0] OUT_LATCH = 3'd0;
  localparam logic [2:0] IN_PORT   = 3'd1;
  localparam logic [2:0] PORT_MUX  = 3'd3;
  localparam logic [2:0] ADC_HIGH  = 3'd4;
  localparam logic [2:0] ADC_LOW   = 3'd5;

  localparam logic [3:0] BOARD_ALL = 4'd5;

  typedef logic [1:0] mux_state_t;

  localparam mux_state_t MUX_IDLE  = 2'd0;
  localparam mux_state_t MUX_ARMED = 2'd1;
  localparam mux_state_t MUX_CONV  = 2'd2;

  typedef enum logic {
    ENABLE  = 1'b0,
    DISABLE = 1'b1
  } strobe_e;

  function automatic logic [7:0] read_mux(
    input logic [2:0]  port,
    input logic [7:0]  pins,
    input logic [15:0] result,
    input logic [7:0]  latch
  );
    logic [7:0] d;
    d = 8'hFF;
    unique case (1'b1)
      (port == IN_PORT):   d = pins;
      (port == ADC_HIGH):  d = result[15:8];
      (port == ADC_LOW):   d = result[7:0];
      (port == OUT_LATCH): d = latch;
      default:             d = 8'hFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_bus_board_responder_if.sv
// Card-side Phase Bus signals between the master and one responder.
// The master owns select, address, strobes and its data; the card owns readback.
interface phase_bus_board_responder_if;

  logic [3:0] BOARD_X;
  logic [2:0] AddessPortPin;
  logic       RdP;
  logic       WrP;
  logic [7:0] bus_data_in;
  logic       master_data_dir;
  logic [7:0] bus_data_out;
  logic       bus_drive_en;

  modport master (
    output BOARD_X,
    output AddessPortPin,
    output RdP,
    output WrP,
    output bus_data_in,
    output master_data_dir,
    input  bus_data_out,
    input  bus_drive_en
  );

  modport slave (
    input  BOARD_X,
    input  AddessPortPin,
    input  RdP,
    input  WrP,
    input  bus_data_in,
    input  master_data_dir,
    output bus_data_out,
    output bus_drive_en
  );

endinterface

// File: rtl/phase_bus_board_responder_sync.sv
// Two-flop strobe synchroniser with registered edge detect.
// Resets to the idle (deasserted-high) level so release never fakes an edge.
module pb_strobe_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
      q_d  <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/phase_bus_board_responder.sv
// Emulated Phase Bus I/O card: register writes, readback drive,
// and the mux-latch / ADC-start handshake used by pb_adc4.
module phase_bus_board_responder
  import phase_bus_pkg::*;
#(
  parameter logic [3:0] BOARD_ID        = 4'd1,
  parameter logic [3:0] BOARD_ALL_CODE  = BOARD_ALL,
  parameter int         CLOCK_FREQUENCY = 27000000
) (
  input  logic        clock,
  input  logic        reset,
  phase_bus_board_responder_if.slave bus,
  output logic [7:0]  out_latch,
  input  logic [7:0]  in_pins,
  output logic [2:0]  adc_channel,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [15:0] adc_result,
  output logic        adc_busy,
  output logic        proto_error
);

  logic       rd_q, rd_rise, rd_fall;
  logic       wr_q, wr_rise, wr_fall;
  logic [3:0] board_m, board_s;
  logic [2:0] addr_m, addr_s;
  logic [7:0] data_m, data_s;
  logic [7:0] pins_m, pins_s;
  logic       dir_m, dir_s;

  pb_strobe_sync u_rd_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.RdP),
    .q     (rd_q),
    .rise  (rd_rise),
    .fall  (rd_fall)
  );

  pb_strobe_sync u_wr_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.WrP),
    .q     (wr_q),
    .rise  (wr_rise),
    .fall  (wr_fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      board_m <= '0;
      board_s <= '0;
      addr_m  <= '0;
      addr_s  <= '0;
      data_m  <= '0;
      data_s  <= '0;
      pins_m  <= '0;
      pins_s  <= '0;
      dir_m   <= 1'b0;
      dir_s   <= 1'b0;
    end else begin
      board_m <= bus.BOARD_X;
      board_s <= board_m;
      addr_m  <= bus.AddessPortPin;
      addr_s  <= addr_m;
      data_m  <= bus.bus_data_in;
      data_s  <= data_m;
      pins_m  <= in_pins;
      pins_s  <= pins_m;
      dir_m   <= bus.master_data_dir;
      dir_s   <= dir_m;
    end
  end

  logic sel_wr, sel_rd;
  logic both_low, both_low_d;
  logic wr_clean, wr_hit, mux_wr;
  logic drive_req;

  assign sel_wr = (board_s == BOARD_ID) ||
                  (board_s == BOARD_ALL_CODE);
  assign sel_rd = (board_s == BOARD_ID);

  assign both_low = (rd_q == ENABLE) &&
                    (wr_q == ENABLE);

  // A write pulse that ever overlapped RdP is poisoned until the next fall
  assign wr_hit = wr_rise && wr_clean && sel_wr;
  assign mux_wr = wr_hit && (addr_s == PORT_MUX);

  assign drive_req = (rd_q == ENABLE) &&
                     (wr_q == DISABLE) &&
                     sel_rd && !dir_s;

  mux_state_t mux_state;
  logic [15:0] result;
  logic        drive_en;
  logic [7:0]  data_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      both_low_d  <= 1'b0;
      proto_error <= 1'b0;
      wr_clean    <= 1'b0;
      out_latch   <= '0;
      adc_channel <= '0;
      adc_start   <= 1'b0;
      adc_busy    <= 1'b0;
      result      <= '0;
      mux_state   <= MUX_IDLE;
      drive_en    <= 1'b0;
      data_out    <= '0;
    end else begin
      both_low_d <= both_low;
      if (both_low && both_low_d)
        proto_error <= 1'b1;

      if (wr_fall)
        wr_clean <= (rd_q == DISABLE);
      else if (both_low)
        wr_clean <= 1'b0;

      if (wr_hit && (addr_s == OUT_LATCH))
        out_latch <= data_s;

      adc_start <= 1'b0;
      case (mux_state)
        MUX_IDLE: begin
          if (mux_wr) begin
            adc_channel <= data_s[2:0];
            mux_state   <= MUX_ARMED;
          end
        end
        MUX_ARMED: begin
          if (mux_wr) begin
            adc_start <= 1'b1;
            adc_busy  <= 1'b1;
            mux_state <= MUX_CONV;
          end
        end
        MUX_CONV: begin
          if (adc_done) begin
            result    <= adc_result;
            adc_busy  <= 1'b0;
            mux_state <= MUX_IDLE;
          end
        end
        default: mux_state <= MUX_IDLE;
      endcase

      // Readback is frozen at the first drive cycle and held until release
      drive_en <= drive_req;
      if (drive_req && !drive_en)
        data_out <= read_mux(addr_s, pins_s,
                             result, out_latch);
      else if (!drive_req)
        data_out <= '0;
    end
  end

  assign bus.bus_drive_en = drive_en;
  assign bus.bus_data_out = data_out;

  logic unused_ok;
  assign unused_ok = ^{CLOCK_FREQUENCY, rd_rise, rd_fall};

endmodule

// File: tb/tb_phase_bus_board_responder.sv
// Directed bench for the Phase Bus card responder.
// Drives strobes at posedge+1 and samples outputs there too.
module tb_phase_bus_board_responder;

  logic        clock;
  logic        reset;
  logic [7:0]  out_latch;
  logic [7:0]  in_pins;
  logic [2:0]  adc_channel;
  logic        adc_start;
  logic        adc_done;
  logic [15:0] adc_result;
  logic        adc_busy;
  logic        proto_error;

  int checks;
  int errors;
  int start_cnt;
  int base;

  phase_bus_board_responder_if bus ();

  phase_bus_board_responder #(
    .BOARD_ID        (4'd1),
    .BOARD_ALL_CODE  (4'd5),
    .CLOCK_FREQUENCY (27000000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .out_latch   (out_latch),
    .in_pins     (in_pins),
    .adc_channel (adc_channel),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_result  (adc_result),
    .adc_busy    (adc_busy),
    .proto_error (proto_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial start_cnt = 0;
  always @(negedge clock)
    if (adc_start) start_cnt = start_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] b,
                    input logic [2:0] p,
                    input logic [7:0] d);
    bus.BOARD_X         = b;
    bus.AddessPortPin   = p;
    bus.bus_data_in     = d;
    bus.master_data_dir = 1'b1;
    cyc(3);
    bus.WrP = 1'b0;
    cyc(20);
    bus.WrP = 1'b1;
    cyc(4);
  endtask

  task automatic rd(input logic [3:0] b,
                    input logic [2:0] p,
                    input logic       exp_en,
                    input logic [7:0] exp_d,
                    input string      tag);
    bus.BOARD_X         = b;
    bus.AddessPortPin   = p;
    bus.master_data_dir = 1'b0;
    cyc(3);
    bus.RdP = 1'b0;
    cyc(3);
    chk({tag, "_en"}, 16'(bus.bus_drive_en), 16'(exp_en));
    if (exp_en)
      chk({tag, "_data"}, 16'(bus.bus_data_out), 16'(exp_d));
    cyc(14);
    chk({tag, "_en_hold"}, 16'(bus.bus_drive_en), 16'(exp_en));
    if (exp_en)
      chk({tag, "_data_hold"}, 16'(bus.bus_data_out), 16'(exp_d));
    bus.RdP = 1'b1;
    cyc(3);
    chk({tag, "_release"}, 16'(bus.bus_drive_en), 16'd0);
    bus.master_data_dir = 1'b1;
    cyc(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.BOARD_X         = 4'd0;
    bus.AddessPortPin   = 3'd0;
    bus.RdP             = 1'b1;
    bus.WrP             = 1'b1;
    bus.bus_data_in     = 8'd0;
    bus.master_data_dir = 1'b1;
    in_pins    = 8'd0;
    adc_done   = 1'b0;
    adc_result = 16'd0;
    reset      = 1'b0;
    cyc(3);
    chk("rst_out_latch", 16'(out_latch), 16'd0);
    chk("rst_drive_en", 16'(bus.bus_drive_en), 16'd0);
    chk("rst_data_out", 16'(bus.bus_data_out), 16'd0);
    chk("rst_channel", 16'(adc_channel), 16'd0);
    chk("rst_start", 16'(adc_start), 16'd0);
    chk("rst_busy", 16'(adc_busy), 16'd0);
    chk("rst_proto", 16'(proto_error), 16'd0);
    reset = 1'b1;
    cyc(3);

    // own-board write and readback
    wr(4'd1, 3'd0, 8'hA5);
    chk("wr_own_latch", 16'(out_latch), 16'h00A5);
    rd(4'd1, 3'd0, 1'b1, 8'hA5, "rd_latch");

    // broadcast write accepted, broadcast read ignored
    wr(4'd5, 3'd0, 8'h3C);
    chk("wr_bcast_latch", 16'(out_latch), 16'h003C);
    rd(4'd5, 3'd0, 1'b0, 8'h00, "rd_bcast");

    // non-latch port write is ignored
    wr(4'd1, 3'd1, 8'h99);
    chk("wr_inport_ign", 16'(out_latch), 16'h003C);

    // adc sequence
    base = start_cnt;
    wr(4'd1, 3'd3, 8'h06);
    chk("mux_channel", 16'(adc_channel), 16'd6);
    chk("mux_armed_busy", 16'(adc_busy), 16'd0);
    chk("mux_armed_nostart", 16'(start_cnt - base), 16'd0);
    wr(4'd1, 3'd3, 8'hFF);
    chk("conv_start_once", 16'(start_cnt - base), 16'd1);
    chk("conv_busy", 16'(adc_busy), 16'd1);
    chk("conv_channel_kept", 16'(adc_channel), 16'd6);
    wr(4'd1, 3'd3, 8'h02);
    chk("conv_mux_ign", 16'(start_cnt - base), 16'd1);
    chk("conv_channel_ign", 16'(adc_channel), 16'd6);
    rd(4'd1, 3'd4, 1'b1, 8'h00, "rd_prev_hi");
    adc_result = 16'h1234;
    adc_done   = 1'b1;
    cyc(1);
    adc_done   = 1'b0;
    adc_result = 16'hFFFF;
    cyc(1);
    chk("done_busy", 16'(adc_busy), 16'd0);
    rd(4'd1, 3'd4, 1'b1, 8'h12, "rd_adc_hi");
    rd(4'd1, 3'd5, 1'b1, 8'h34, "rd_adc_lo");

    // stray done in IDLE
    adc_result = 16'h5555;
    adc_done   = 1'b1;
    cyc(1);
    adc_done   = 1'b0;
    cyc(1);
    rd(4'd1, 3'd5, 1'b1, 8'h34, "rd_stray_done");

    // input pins and undefined port
    in_pins = 8'h81;
    rd(4'd1, 3'd1, 1'b1, 8'h81, "rd_inport");
    rd(4'd1, 3'd7, 1'b1, 8'hFF, "rd_undef");

    // wrong board, master driving, contention
    rd(4'd2, 3'd1, 1'b0, 8'h00, "rd_wrong_board");
    bus.BOARD_X         = 4'd1;
    bus.AddessPortPin   = 3'd1;
    bus.master_data_dir = 1'b1;
    cyc(3);
    bus.RdP = 1'b0;
    cyc(5);
    chk("rd_dir_high", 16'(bus.bus_drive_en), 16'd0);
    bus.master_data_dir = 1'b0;
    cyc(3);
    chk("cont_drive_on", 16'(bus.bus_drive_en), 16'd1);
    bus.master_data_dir = 1'b1;
    cyc(3);
    chk("cont_drive_off", 16'(bus.bus_drive_en), 16'd0);
    bus.RdP = 1'b1;
    cyc(4);

    // both strobes low
    bus.BOARD_X       = 4'd1;
    bus.AddessPortPin = 3'd0;
    bus.bus_data_in   = 8'h77;
    cyc(3);
    chk("proto_before", 16'(proto_error), 16'd0);
    bus.RdP = 1'b0;
    bus.WrP = 1'b0;
    cyc(3);
    chk("proto_nodrive", 16'(bus.bus_drive_en), 16'd0);
    bus.RdP = 1'b1;
    bus.WrP = 1'b1;
    cyc(6);
    chk("proto_set", 16'(proto_error), 16'd1);
    chk("proto_latch", 16'(out_latch), 16'h003C);

    // reset during conversion
    wr(4'd1, 3'd3, 8'h02);
    wr(4'd1, 3'd3, 8'h00);
    chk("rst_conv_busy", 16'(adc_busy), 16'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_busy", 16'(adc_busy), 16'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    adc_result = 16'hABCD;
    adc_done   = 1'b1;
    cyc(1);
    adc_done   = 1'b0;
    cyc(2);
    chk("rst_done_busy", 16'(adc_busy), 16'd0);
    chk("rst_done_proto", 16'(proto_error), 16'd0);
    chk("rst_done_latch", 16'(out_latch), 16'd0);
    chk("rst_done_chan", 16'(adc_channel), 16'd0);
    rd(4'd1, 3'd4, 1'b1, 8'h00, "rd_rst_hi");
    rd(4'd1, 3'd5, 1'b1, 8'h00, "rd_rst_lo");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
